// File: rtl/sim_uart_mmio.sv
// Memory-mapped console UART on a data-SRAM-style bus: stores at THR feed a TX FIFO that drains
// as io_uart_out pulses; the console is polled periodically for one RX byte held in RBR.
module sim_uart_mmio #(
    parameter logic [63:0] BASE_ADDR = 64'h1000_0000,
    parameter int unsigned TX_DEPTH  = 16,
    parameter int unsigned TX_GAP    = 0,
    parameter int unsigned RX_POLL   = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic [7:0]  we,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic [63:0] rdata,
    output logic        io_uart_out_valid,
    output logic [7:0]  io_uart_out_ch,
    output logic        io_uart_in_valid,
    input  logic [7:0]  io_uart_in_ch
);

    localparam int unsigned PtrW = $clog2(TX_DEPTH);
    localparam int unsigned GapW = (TX_GAP > 0) ? $clog2(TX_GAP + 1) : 1;
    localparam int unsigned RxW  = $clog2(RX_POLL + 1);

    logic [7:0]      fifo_q [TX_DEPTH];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [PtrW:0]   count_q;
    logic [GapW-1:0] gap_q;
    logic [RxW-1:0]  rx_cnt_q;
    logic            dr_q, oe_q;
    logic [7:0]      rbr_q;

    logic       hit, rd_acc, push_req, push, pop, drop;
    logic       fifo_full, fifo_empty, temt, thre, poll_fire, rx_hit;
    logic [7:0] lsr;
    logic       unused_bits;

    assign hit        = en && (addr[63:3] == BASE_ADDR[63:3]);
    assign rd_acc     = hit && (we == 8'h00);
    assign push_req   = hit && we[0];
    assign fifo_full  = (count_q == (PtrW + 1)'(TX_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign pop        = !fifo_empty && (gap_q == '0);
    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign push       = push_req && (!fifo_full || pop);
    assign drop       = push_req && fifo_full && !pop;
    assign thre       = !fifo_full;
    assign temt       = fifo_empty && (gap_q == '0);
    assign lsr        = {1'b0, temt, thre, 3'b000, oe_q, dr_q};
    assign poll_fire  = !dr_q && (rx_cnt_q == RxW'(1));
    assign rx_hit     = io_uart_in_valid && (io_uart_in_ch != 8'hFF);
    assign unused_bits = ^{addr[2:0], wdata[63:8]};

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= wdata[7:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata             <= '0;
            io_uart_out_valid <= 1'b0;
            io_uart_out_ch    <= 8'h00;
            io_uart_in_valid  <= 1'b0;
            rd_ptr_q          <= '0;
            wr_ptr_q          <= '0;
            count_q           <= '0;
            gap_q             <= '0;
            rx_cnt_q          <= RxW'(RX_POLL);
            dr_q              <= 1'b0;
            oe_q              <= 1'b0;
            rbr_q             <= 8'h00;
        end else begin
            rdata <= rd_acc ? {16'h0000, lsr, 32'h0000_0000, rbr_q} : '0;

            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end

            if (pop) begin
                rd_ptr_q          <= rd_ptr_q + PtrW'(1);
                io_uart_out_ch    <= fifo_q[rd_ptr_q];
                io_uart_out_valid <= 1'b1;
                gap_q             <= GapW'(TX_GAP);
            end else begin
                io_uart_out_valid <= 1'b0;
                if (gap_q != '0) begin
                    gap_q <= gap_q - GapW'(1);
                end
            end

            if (push && !pop) begin
                count_q <= count_q + (PtrW + 1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (PtrW + 1)'(1);
            end

            if (drop) begin
                oe_q <= 1'b1;
            end else if (rd_acc) begin
                oe_q <= 1'b0;
            end

            io_uart_in_valid <= poll_fire;

            // A poll result landing on the same edge as a clearing read keeps DR set.
            if (rx_hit) begin
                rbr_q <= io_uart_in_ch;
                dr_q  <= 1'b1;
            end else if (rd_acc) begin
                dr_q <= 1'b0;
            end

            if (dr_q || rx_hit || poll_fire) begin
                rx_cnt_q <= RxW'(RX_POLL);
            end else if (rx_cnt_q != '0) begin
                rx_cnt_q <= rx_cnt_q - RxW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sim_uart_mmio.sv
// Scoreboard bench for sim_uart_mmio: expected TX bytes and read data are queued with the cycle
// they must appear in; a negedge monitor pops and compares them as the DUT presents them.
module tb_sim_uart_mmio;

    localparam logic [63:0] BASE = 64'h1000_0000;

    typedef struct {
        logic [63:0] v;
        int          c;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        en;
    logic [7:0]  we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        io_uart_out_valid;
    logic [7:0]  io_uart_out_ch;
    logic        io_uart_in_valid;
    logic [7:0]  io_uart_in_ch;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_tx[$];
    exp_t exp_rd[$];
    int   poll_q[$];

    sim_uart_mmio #(
        .BASE_ADDR(BASE),
        .TX_DEPTH (16),
        .TX_GAP   (3),
        .RX_POLL  (4)
    ) u_dut (
        .clock            (clock),
        .reset            (reset),
        .en               (en),
        .we               (we),
        .addr             (addr),
        .wdata            (wdata),
        .rdata            (rdata),
        .io_uart_out_valid(io_uart_out_valid),
        .io_uart_out_ch   (io_uart_out_ch),
        .io_uart_in_valid (io_uart_in_valid),
        .io_uart_in_ch    (io_uart_in_ch)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every TX pulse and every due read response against the queues.
    always @(negedge clock) begin
        exp_t e;
        if (io_uart_out_valid) begin
            if (exp_tx.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: got ch %h at cycle %0d, expected no pulse",
                         io_uart_out_ch, cyc);
            end else begin
                e = exp_tx.pop_front();
                chk("tx_ch", {56'h0, io_uart_out_ch}, e.v);
                chk("tx_cycle", 64'(cyc), 64'(e.c));
            end
        end
        if (exp_rd.size() != 0 && exp_rd[0].c == cyc) begin
            e = exp_rd.pop_front();
            chk("rdata", rdata, e.v);
        end
        if (io_uart_in_valid) poll_q.push_back(cyc);
    end

    task automatic bus(input logic e, input logic [7:0] w, input logic [63:0] a,
                       input logic [63:0] d);
        en = e; we = w; addr = a; wdata = d;
        @(posedge clock);
        #1;
        en = 1'b0; we = 8'h00; addr = '0; wdata = '0;
    endtask

    task automatic push_tx(input logic [7:0] ch, input int c);
        exp_t e;
        e.v = {56'h0, ch};
        e.c = c;
        exp_tx.push_back(e);
    endtask

    task automatic rd(input logic [63:0] a, input logic [63:0] exp);
        exp_t e;
        e.v = exp;
        e.c = cyc + 1;
        exp_rd.push_back(e);
        bus(1'b1, 8'h00, a, '0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Returns the cycle number of the reset edge, then checks reset output values.
    task automatic do_reset(output int r);
        reset = 1'b1;
        en    = 1'b0;
        @(posedge clock);
        #1;
        r     = cyc;
        reset = 1'b0;
        poll_q.delete();
        @(negedge clock);
        chk("rst_rdata", rdata, '0);
        chk("rst_out_valid", {63'h0, io_uart_out_valid}, '0);
        chk("rst_out_ch", {56'h0, io_uart_out_ch}, '0);
        chk("rst_in_valid", {63'h0, io_uart_in_valid}, '0);
    endtask

    task automatic chk_polls(input string name, input int exp[$]);
        chk({name, "_count"}, 64'(poll_q.size()), 64'(exp.size()));
        foreach (exp[i]) chk(name, (i < poll_q.size()) ? 64'(poll_q[i]) : '1, 64'(exp[i]));
    endtask

    initial begin
        int r;
        int n;
        reset = 1'b1; en = 1'b0; we = 8'h00; addr = '0; wdata = '0;
        io_uart_in_ch = 8'hFF;
        do_reset(r);

        // Single byte: pulse two cycles after the write cycle; LSR reflects the queued byte.
        n = cyc;
        push_tx(8'h41, n + 2);
        bus(1'b1, 8'h01, BASE, 64'h41);
        rd(BASE, 64'h0000_2000_0000_0000);
        idle(6);
        rd(BASE, 64'h0000_6000_0000_0000);
        idle(2);

        // Burst of 24 with TX_GAP=3: FIFO fills after 0x15, so 0x16 and 0x17 overflow.
        n = cyc;
        for (int j = 0; j < 22; j++) push_tx(8'(j), n + 2 + 4 * j);
        for (int i = 0; i < 24; i++) bus(1'b1, 8'h01, BASE, 64'(i));
        rd(BASE, 64'h0000_0200_0000_0000);
        rd(BASE, 64'h0000_0000_0000_0000);
        idle(70);
        rd(BASE, 64'h0000_6000_0000_0000);
        idle(2);

        // No console input: polls every 4 cycles, nothing latched.
        do_reset(r);
        idle(13);
        chk_polls("poll_idle", '{r + 4, r + 8, r + 12});
        rd(BASE, 64'h0000_6000_0000_0000);

        // Console returns 0x7A on the first poll; polling pauses until DR is read.
        do_reset(r);
        io_uart_in_ch = 8'h7A;
        idle(5);
        io_uart_in_ch = 8'hFF;
        idle(3);
        rd(BASE, 64'h0000_6100_0000_007A);
        rd(BASE, 64'h0000_6000_0000_007A);
        idle(8);
        chk_polls("poll_rx", '{r + 4, r + 13, r + 17});

        // Non-hit accesses and the LSR lane are ignored; any offset in the word hits.
        rd(BASE + 64'h8, 64'h0);
        bus(1'b1, 8'h01, BASE + 64'h8, 64'h55);
        bus(1'b1, 8'h20, BASE, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(BASE + 64'h5, 64'h0000_6000_0000_007A);
        idle(8);

        // Reset mid-drain drops the three bytes still queued.
        n = cyc;
        push_tx(8'hA0, n + 2);
        push_tx(8'hA1, n + 6);
        for (int i = 0; i < 5; i++) bus(1'b1, 8'h01, BASE, 64'(8'hA0 + i));
        idle(2);
        do_reset(r);
        idle(6);
        chk_polls("poll_after_rst", '{r + 4});
        rd(BASE, 64'h0000_6000_0000_0000);
        idle(20);

        chk("tx_left", 64'(exp_tx.size()), 64'h0);
        chk("rd_left", 64'(exp_rd.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout at cycle %0d, expected bench completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
